// File: rtl/dbus_peri_router_if.sv
// rtl/dbus_peri_router_if.sv - Bus types and interface between the core dbus, the router and the peripherals
//
// Purpose: this file holds the request/response struct types and the interface that bundles
// the core-side and peripheral-side signals of dbus_peri_router.
// Port summary (interface members):
//   dbus2router_i      core request (addr, w_data, w_en, byte_en, req)
//   router2dbus_o      response to core (r_data, ack)
//   bus_err_o          error flag, meaningful only while router2dbus_o.ack=1
//   dbus2peri_o        latched request broadcast to all peripherals
//   *_sel_o            one-hot peripheral selects
//   *2router_i         per-peripheral responses
// Modports: slave = router view, master = core/peripheral environment view.

package dbus_peri_router_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] w_data;
        logic        w_en;
        logic [3:0]  byte_en;
        logic        req;
    } type_dbus2peri_s;

    typedef struct packed {
        logic [31:0] r_data;
        logic        ack;
    } type_peri2dbus_s;
endpackage

interface dbus_peri_router_if;
    dbus_peri_router_pkg::type_dbus2peri_s dbus2router_i;
    dbus_peri_router_pkg::type_peri2dbus_s router2dbus_o;
    logic                                  bus_err_o;
    dbus_peri_router_pkg::type_dbus2peri_s dbus2peri_o;
    logic                                  clint_sel_o;
    logic                                  plic_sel_o;
    logic                                  uart_sel_o;
    logic                                  gpio_sel_o;
    dbus_peri_router_pkg::type_peri2dbus_s clint2router_i;
    dbus_peri_router_pkg::type_peri2dbus_s plic2router_i;
    dbus_peri_router_pkg::type_peri2dbus_s uart2router_i;
    dbus_peri_router_pkg::type_peri2dbus_s gpio2router_i;

    modport slave (
        input  dbus2router_i,
        input  clint2router_i, plic2router_i, uart2router_i, gpio2router_i,
        output router2dbus_o, bus_err_o, dbus2peri_o,
        output clint_sel_o, plic_sel_o, uart_sel_o, gpio_sel_o
    );

    modport master (
        output dbus2router_i,
        output clint2router_i, plic2router_i, uart2router_i, gpio2router_i,
        input  router2dbus_o, bus_err_o, dbus2peri_o,
        input  clint_sel_o, plic_sel_o, uart_sel_o, gpio_sel_o
    );
endinterface

// File: rtl/dbus_peri_router.sv
// rtl/dbus_peri_router.sv - Core data bus to CLINT/PLIC/UART/GPIO router with timeout
//
// Purpose: decodes a core dbus request, latches it, forwards it to one peripheral with a
// one-hot select, waits for that peripheral's ack (or a timeout) and returns a single-cycle
// response. Unmapped addresses and timeouts return ERR_DATA with bus_err_o=1.
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   dbus_peri_router_if.slave (core request/response, peripheral broadcast,
//         selects and peripheral responses)

module dbus_peri_router
    import dbus_peri_router_pkg::*;
#(
    parameter logic [31:0] CLINT_BASE     = 32'h0200_0000,
    parameter logic [31:0] CLINT_MASK     = 32'hFFFF_0000,
    parameter logic [31:0] PLIC_BASE      = 32'h0C00_0000,
    parameter logic [31:0] PLIC_MASK      = 32'hFC00_0000,
    parameter logic [31:0] UART_BASE      = 32'h9000_0000,
    parameter logic [31:0] UART_MASK      = 32'hFFFF_FF00,
    parameter logic [31:0] GPIO_BASE      = 32'h9000_0100,
    parameter logic [31:0] GPIO_MASK      = 32'hFFFF_FF00,
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input logic               clk,
    input logic               rst,
    dbus_peri_router_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    type_dbus2peri_s r_req;
    logic [3:0]      r_tgt;      // one-hot target: bit0 CLINT, bit1 PLIC, bit2 UART, bit3 GPIO
    logic [7:0]      r_cnt;
    logic [31:0]     r_rdata;
    logic            r_err;

    logic [31:0]     w_addr;
    logic [3:0]      w_dec_tgt;
    logic [3:0]      w_acks;
    logic            w_sel_ack;
    logic [31:0]     w_sel_rdata;
    logic            w_accept;
    logic            w_resp_ok;
    logic            w_resp_err;
    logic            w_in_req;
    logic            w_in_resp;
    type_dbus2peri_s w_peri;
    type_peri2dbus_s w_rsp;

    assign w_addr = bus.dbus2router_i.addr;

    // Priority decode: the earlier region wins if regions ever overlap.
    always_comb begin
        w_dec_tgt = 4'b0000;
        if ((w_addr & CLINT_MASK) == CLINT_BASE)     w_dec_tgt = 4'b0001;
        else if ((w_addr & PLIC_MASK) == PLIC_BASE)  w_dec_tgt = 4'b0010;
        else if ((w_addr & UART_MASK) == UART_BASE)  w_dec_tgt = 4'b0100;
        else if ((w_addr & GPIO_MASK) == GPIO_BASE)  w_dec_tgt = 4'b1000;
    end

    // Only the latched target's ack counts; acks from other peripherals are masked off.
    assign w_acks    = {bus.gpio2router_i.ack, bus.uart2router_i.ack,
                        bus.plic2router_i.ack, bus.clint2router_i.ack};
    assign w_sel_ack = |(r_tgt & w_acks);

    always_comb begin
        w_sel_rdata = '0;
        if (r_tgt[0])      w_sel_rdata = bus.clint2router_i.r_data;
        else if (r_tgt[1]) w_sel_rdata = bus.plic2router_i.r_data;
        else if (r_tgt[2]) w_sel_rdata = bus.uart2router_i.r_data;
        else if (r_tgt[3]) w_sel_rdata = bus.gpio2router_i.r_data;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_resp_ok   = 1'b0;
        w_resp_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.dbus2router_i.req) begin
                    w_accept    = 1'b1;
                    w_resp_err  = ~|w_dec_tgt;
                    w_state_nxt = (|w_dec_tgt) ? S_REQ : S_RESP;
                end
            end
            S_REQ: begin
                // Ack is checked first so an ack in the last allowed cycle still succeeds.
                if (w_sel_ack) begin
                    w_resp_ok   = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (r_cnt == TO_LAST) begin
                    w_resp_err  = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_req   <= '0;
            r_tgt   <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_req <= bus.dbus2router_i;
                r_tgt <= w_dec_tgt;
                r_cnt <= '0;
            end else if (r_state == S_REQ) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_resp_ok) begin
                r_rdata <= w_sel_rdata;
                r_err   <= 1'b0;
            end else if (w_resp_err) begin
                r_rdata <= ERR_DATA;
                r_err   <= 1'b1;
            end
        end
    end

    assign w_in_req  = (r_state == S_REQ);
    assign w_in_resp = (r_state == S_RESP);

    // The broadcast bus always shows the latched fields; only req is gated by state.
    always_comb begin
        w_peri     = r_req;
        w_peri.req = w_in_req;
    end

    always_comb begin
        w_rsp.ack    = w_in_resp;
        w_rsp.r_data = w_in_resp ? r_rdata : '0;
    end

    assign bus.dbus2peri_o   = w_peri;
    assign bus.router2dbus_o = w_rsp;
    assign bus.bus_err_o     = w_in_resp & r_err;
    assign bus.clint_sel_o   = w_in_req & r_tgt[0];
    assign bus.plic_sel_o    = w_in_req & r_tgt[1];
    assign bus.uart_sel_o    = w_in_req & r_tgt[2];
    assign bus.gpio_sel_o    = w_in_req & r_tgt[3];

endmodule

// File: doc/dbus_peri_router.md
Name: dbus_peri_router

Overview:
- Sits between the core-side data bus (LSU/dbus master) and the memory-mapped peripherals: CLINT, PLIC, UART and GPIO.
- Decodes the request address, latches the transaction and drives the broadcast peripheral request bus plus one one-hot select line.
- Waits for the selected peripheral's ack, captures its read data and returns a single-cycle response to the core.
- Unmapped addresses and non-responding peripherals are terminated with an error response, so the core never hangs.

Parameters:
- CLINT_BASE, 32'h0200_0000, CLINT region base.
- CLINT_MASK, 32'hFFFF_0000, CLINT region address mask.
- PLIC_BASE, 32'h0C00_0000, PLIC region base.
- PLIC_MASK, 32'hFC00_0000, PLIC region address mask.
- UART_BASE, 32'h9000_0000, UART region base.
- UART_MASK, 32'hFFFF_FF00, UART region address mask.
- GPIO_BASE, 32'h9000_0100, GPIO region base.
- GPIO_MASK, 32'hFFFF_FF00, GPIO region address mask.
- TIMEOUT_CYCLES, 16, number of REQ-state cycles without ack before the transaction is aborted (range 2..255).
- ERR_DATA, 32'hDEAD_BEEF, r_data returned on an error response.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- dbus2router_i  in  type_dbus2peri_s  core request (addr, w_data, w_en, req, remaining fields)
- router2dbus_o  out  type_peri2dbus_s  response to core (r_data, ack)
- bus_err_o  out  1  error flag, valid only while router2dbus_o.ack=1
- dbus2peri_o  out  type_dbus2peri_s  latched request broadcast to all peripherals
- clint_sel_o, plic_sel_o, uart_sel_o, gpio_sel_o  out  1 each  one-hot peripheral selects
- clint2router_i, plic2router_i, uart2router_i, gpio2router_i  in  type_peri2dbus_s each  peripheral responses

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Decode: region hit when (addr & MASK) == BASE.
  - Multiple hits resolve by priority CLINT > PLIC > UART > GPIO.
  - No hit means unmapped.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - When dbus2router_i.req=1, latch the whole request into req_ff and the decoded target into tgt_ff.
  - Mapped target: go to REQ and clear the timeout counter.
  - Unmapped target: go to RESP with err_ff=1 and rdata_ff=ERR_DATA.
- REQ:
  - dbus2peri_o = req_ff with req forced to 1; only sel[tgt_ff]=1.
  - The timeout counter increments every cycle.
  - If the selected peripheral's ack=1: rdata_ff <= that peripheral's r_data (writes also capture it; the core ignores it), err_ff=0, go to RESP.
  - Otherwise, if counter == TIMEOUT_CYCLES-1: rdata_ff=ERR_DATA, err_ff=1, go to RESP.
  - If ack and timeout occur in the same cycle, ack wins.
- RESP:
  - router2dbus_o.ack=1 for exactly one cycle, with r_data=rdata_ff and bus_err_o=err_ff.
  - All sels=0 and dbus2peri_o.req=0.
  - Always go to IDLE.
- Outside RESP: router2dbus_o.ack=0, r_data=0, bus_err_o=0.
- Outside REQ: all sels=0 and dbus2peri_o.req=0; the other dbus2peri_o fields hold req_ff.
- Request latching:
  - Core request fields are sampled only in IDLE. Changes on dbus2router_i during REQ/RESP are ignored.
  - A req still high in the cycle after RESP is a new transaction.
- Acks from non-selected peripherals, or any ack in IDLE/RESP, are ignored.
- Latency:
  - Accept edge at cycle t; REQ during t+1.
  - A peripheral that acks one cycle after sel (e.g. CLINT) acks at t+2, so the core sees ack at t+3.
  - Unmapped requests see ack at t+1.
- Reset (including mid-transaction):
  - Next cycle: state=IDLE, all sels=0, dbus2peri_o='0, router2dbus_o='0, bus_err_o=0, counter=0.
  - A late peripheral ack after reset is ignored.
- Only one transaction is outstanding at a time; there is no pipelining.

Test Plan:
- CLINT read: req addr 32'h0200_0000 (mtime low) after reset with model ack at sel+1, r_data 32'h0000_0005 -> clint_sel_o high exactly in cycle t+1..t+2, core ack at t+3 with r_data 32'h0000_0005, bus_err_o=0.
- CLINT write: w_en=1, addr 32'h0200_0008, w_data 32'h0000_1234 -> dbus2peri_o carries addr/w_data/w_en=1 during REQ, core ack pulse one cycle, bus_err_o=0, no second write issued.
- Unmapped: addr 32'h4000_0000 -> no sel asserted, ack at t+1 with r_data 32'hDEAD_BEEF, bus_err_o=1.
- Timeout: UART addr 32'h9000_0004 with UART never acking -> uart_sel_o high for 16 cycles, then ack with r_data 32'hDEAD_BEEF, bus_err_o=1.
- Ack filtering and hold: GPIO request; PLIC asserts ack spuriously during REQ; core changes addr during REQ -> PLIC ack ignored, GPIO data returned, dbus2peri_o.addr stays 32'h9000_0100.
- Reset mid-REQ: assert rst during CLINT REQ, then CLINT acks -> next cycle all outputs zero, state IDLE, no core ack produced.
